// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the uart byte-command responder.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] CMD_PING = 8'h50;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_ADDR = 3'd1,
        ST_GET_DATA = 3'd2,
        ST_BUS_WR   = 3'd3,
        ST_BUS_RD   = 3'd4,
        ST_RD_WAIT  = 3'd5,
        ST_SEND     = 3'd6
    } state_e;

    // An address byte is usable only when every bit above the bus width is zero.
    function automatic logic addr_in_range(input logic [7:0] addr_byte, input int unsigned aw);
        return (addr_byte >> aw) == 8'd0;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter: counts enabled cycles and pulses done on the last one.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int unsigned    CW    = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  ONE   = CW'(32'd1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // A clear in the same cycle always wins over expiry, so done never fires then.
    assign done = en && !clr && (count_q == LIMIT);

    // Next count: clear, wrap on expiry, or advance while enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CW{1'b0}};
        end else if (en) begin
            if (count_q == LIMIT) begin
                count_d = {CW{1'b0}};
            end else begin
                count_d = count_q + ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes W/R/P byte commands from the rx FIFO into register-bus accesses
// and answers each accepted command with one byte into the tx FIFO.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rx_empty,
    input  logic [7:0]    r_data,
    output logic          rd_uart,
    input  logic          tx_full,
    output logic [7:0]    w_data,
    output logic          wr_uart,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    output logic          reg_re,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          timeout_err
);

    state_e        state_q,       state_d;
    logic [7:0]    cmd_q,         cmd_d;
    logic          addr_bad_q,    addr_bad_d;
    logic [AW-1:0] reg_addr_q,    reg_addr_d;
    logic [7:0]    reg_wdata_q,   reg_wdata_d;
    logic [7:0]    rsp_q,         rsp_d;
    logic [7:0]    w_data_q,      w_data_d;
    logic          rd_uart_q,     rd_uart_d;
    logic          wr_uart_q,     wr_uart_d;
    logic          reg_we_q,      reg_we_d;
    logic          reg_re_q,      reg_re_d;
    logic          busy_q,        busy_d;
    logic          timeout_err_q, timeout_err_d;

    logic          pop_s;
    logic          addr_ok_s;
    logic          rx_wait_s;
    logic          tmo_clr_s;
    logic          tmo_done_s;

    // The FIFO head is stale during the cycle our own pop is being applied.
    assign pop_s     = !rx_empty && !rd_uart_q;
    assign addr_ok_s = addr_in_range(r_data, AW);
    assign rx_wait_s = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
    assign tmo_clr_s = !rx_wait_s || pop_s;

    uart_cmd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (tmo_clr_s),
        .en      (rx_wait_s),
        .done    (tmo_done_s)
    );

    // Next-state and next-output logic; strobes are raised on entry to the state they belong to.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        addr_bad_d    = addr_bad_q;
        reg_addr_d    = reg_addr_q;
        reg_wdata_d   = reg_wdata_q;
        rsp_d         = rsp_q;
        w_data_d      = w_data_q;
        rd_uart_d     = 1'b0;
        wr_uart_d     = 1'b0;
        reg_we_d      = 1'b0;
        reg_re_d      = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    rd_uart_d = 1'b1;
                    cmd_d     = r_data;
                    if ((r_data == CMD_WR) || (r_data == CMD_RD)) begin
                        state_d = ST_GET_ADDR;
                    end else if (r_data == CMD_PING) begin
                        rsp_d   = RSP_OK;
                        state_d = ST_SEND;
                    end else begin
                        rsp_d   = RSP_ERR;
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_GET_ADDR: begin
                if (pop_s) begin
                    rd_uart_d  = 1'b1;
                    addr_bad_d = !addr_ok_s;
                    if (addr_ok_s) begin
                        reg_addr_d = r_data[AW-1:0];
                    end else begin
                        reg_addr_d = reg_addr_q;
                    end
                    // A write still has to swallow its data byte even with a bad address.
                    if (cmd_q == CMD_WR) begin
                        state_d = ST_GET_DATA;
                    end else if (addr_ok_s) begin
                        reg_re_d = 1'b1;
                        state_d  = ST_BUS_RD;
                    end else begin
                        rsp_d   = RSP_ERR;
                        state_d = ST_SEND;
                    end
                end else if (tmo_done_s) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_GET_ADDR;
                end
            end

            ST_GET_DATA: begin
                if (pop_s) begin
                    rd_uart_d = 1'b1;
                    if (!addr_bad_q) begin
                        reg_wdata_d = r_data;
                        reg_we_d    = 1'b1;
                        state_d     = ST_BUS_WR;
                    end else begin
                        rsp_d   = RSP_ERR;
                        state_d = ST_SEND;
                    end
                end else if (tmo_done_s) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_GET_DATA;
                end
            end

            ST_BUS_WR: begin
                rsp_d   = RSP_OK;
                state_d = ST_SEND;
            end

            ST_BUS_RD: begin
                state_d = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                rsp_d   = reg_rdata;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (!tx_full) begin
                    wr_uart_d = 1'b1;
                    w_data_d  = rsp_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmd_q         <= 8'd0;
            addr_bad_q    <= 1'b0;
            reg_addr_q    <= {AW{1'b0}};
            reg_wdata_q   <= 8'd0;
            rsp_q         <= 8'd0;
            w_data_q      <= 8'd0;
            rd_uart_q     <= 1'b0;
            wr_uart_q     <= 1'b0;
            reg_we_q      <= 1'b0;
            reg_re_q      <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_bad_q    <= addr_bad_d;
            reg_addr_q    <= reg_addr_d;
            reg_wdata_q   <= reg_wdata_d;
            rsp_q         <= rsp_d;
            w_data_q      <= w_data_d;
            rd_uart_q     <= rd_uart_d;
            wr_uart_q     <= wr_uart_d;
            reg_we_q      <= reg_we_d;
            reg_re_q      <= reg_re_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign rd_uart     = rd_uart_q;
    assign wr_uart     = wr_uart_q;
    assign w_data      = w_data_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wdata   = reg_wdata_q;
    assign reg_we      = reg_we_q;
    assign reg_re      = reg_re_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: FIFO and register-bus models, table vectors,
// directed corner cases and randomized frames against a frame-level model.
module tb_uart_cmd_responder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'd0;
    logic       busy;
    logic       timeout_err;

    uart_cmd_responder #(.AW(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // rx FIFO model (first-word-fall-through)
    logic [7:0]  fifo_mem [256];
    logic [31:0] wr_ptr = 32'd0;
    logic [31:0] rd_ptr = 32'd0;
    assign rx_empty = (wr_ptr == rd_ptr);
    assign r_data   = fifo_mem[rd_ptr[7:0]];

    // Monitor / environment state, written only by the monitor process
    logic [7:0]  bus_mem [16];
    logic        mem_ready    = 1'b0;
    int          cyc          = 0;
    int          last_pop_cyc = 0;
    int          tmo_cyc      = 0;
    int          tmo_cnt      = 0;
    int          tx_cnt       = 0;
    int          we_cnt       = 0;
    int          re_cnt       = 0;
    int          underflow    = 0;
    logic [7:0]  last_tx      = 8'd0;
    logic [7:0]  we_addr      = 8'd0;
    logic [7:0]  we_data      = 8'd0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] model_regs [16];

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 7 + 3);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) bus_mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end
        if (rd_uart) begin
            if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 32'd1;
            else underflow <= underflow + 1;
            last_pop_cyc <= cyc;
        end
        if (wr_uart) begin
            tx_cnt  <= tx_cnt + 1;
            last_tx <= w_data;
        end
        if (reg_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= {4'd0, reg_addr};
            we_data <= reg_wdata;
            bus_mem[reg_addr] <= reg_wdata;
        end
        if (reg_re) begin
            re_cnt    <= re_cnt + 1;
            reg_rdata <= bus_mem[reg_addr];
        end else begin
            reg_rdata <= 8'($urandom);
        end
        if (timeout_err) begin
            tmo_cnt <= tmo_cnt + 1;
            tmo_cyc <= cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 32'd1;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int n, input int max_gap);
        logic [7:0] bytes [3];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        push(bytes[0]);
        for (int k = 1; k < n; k++) begin
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            push(bytes[k]);
        end
    endtask

    task automatic wait_rsp(input int t0, input bit rand_full);
        int budget = 300;
        while (tx_cnt == t0 && budget > 0) begin
            @(negedge clk);
            if (rand_full) tx_full = ($urandom_range(0, 2) == 0);
            budget--;
        end
        tx_full = 1'b0;
        chk("rsp_seen", 32'(tx_cnt != t0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [31:0] all_outs();
        return {6'd0, rd_uart, wr_uart, reg_we, reg_re, busy, timeout_err, w_data, reg_wdata, reg_addr};
    endfunction

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         n;
        logic [7:0] rsp;
        bit         we, re;
        logic [7:0] addr, wdata;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_tx, t_we, t_re, t_tmo, n;
        logic [7:0] b0, b1, b2, exp_rsp;
        bit exp_we, exp_re;

        tbl[0] = '{8'h57, 8'h03, 8'hA5, 3, 8'h4B, 1'b1, 1'b0, 8'h03, 8'hA5};
        tbl[1] = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[2] = '{8'h41, 8'h00, 8'h00, 1, 8'h3F, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[3] = '{8'h52, 8'h20, 8'h00, 2, 8'h3F, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[4] = '{8'h50, 8'h00, 8'h00, 1, 8'h4B, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[5] = '{8'h57, 8'h20, 8'h77, 3, 8'h3F, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[6] = '{8'h57, 8'h0F, 8'h5A, 3, 8'h4B, 1'b1, 1'b0, 8'h0F, 8'h5A};
        tbl[7] = '{8'h52, 8'h0F, 8'h00, 2, 8'h5A, 1'b0, 1'b1, 8'h00, 8'h00};
        tbl[8] = '{8'h52, 8'h10, 8'h00, 2, 8'h3F, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[9] = '{8'h57, 8'h00, 8'hC3, 3, 8'h4B, 1'b1, 1'b0, 8'h00, 8'hC3};
        for (int i = 0; i < 16; i++) model_regs[i] = init_val(i);

        reset_n = 1'b0;
        tx_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            t_tx = tx_cnt; t_we = we_cnt; t_re = re_cnt;
            send_frame(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].n, 2);
            wait_rsp(t_tx, 1'b0);
            chk($sformatf("tbl%0d_rsp", i), 32'(last_tx), 32'(tbl[i].rsp));
            chk($sformatf("tbl%0d_we", i), 32'(we_cnt - t_we), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_re", i), 32'(re_cnt - t_re), 32'(tbl[i].re));
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_waddr", i), 32'(we_addr), 32'(tbl[i].addr));
                chk($sformatf("tbl%0d_wdata", i), 32'(we_data), 32'(tbl[i].wdata));
                model_regs[tbl[i].addr[3:0]] = tbl[i].wdata;
            end
            chk($sformatf("tbl%0d_drained", i), 32'(wr_ptr == rd_ptr), 32'd1);
            chk($sformatf("tbl%0d_idle", i), 32'(busy), 32'd0);
        end

        // Timeout on a stalled write frame
        t_tx = tx_cnt; t_tmo = tmo_cnt;
        push(8'h57); push(8'h01);
        n = 60;
        while (tmo_cnt == t_tmo && n > 0) begin @(negedge clk); n--; end
        repeat (3) @(negedge clk);
        chk("tmo_pulses", 32'(tmo_cnt - t_tmo), 32'd1);
        chk("tmo_latency", 32'(tmo_cyc - last_pop_cyc), 32'd16);
        chk("tmo_no_rsp", 32'(tx_cnt - t_tx), 32'd0);
        chk("tmo_idle", 32'(busy), 32'd0);
        t_tx = tx_cnt;
        send_frame(8'h50, 8'h00, 8'h00, 1, 0);
        wait_rsp(t_tx, 1'b0);
        chk("tmo_ping_rsp", 32'(last_tx), 32'h4B);

        // Back-pressure holds the response in SEND
        t_tx = tx_cnt;
        tx_full = 1'b1;
        push(8'h50);
        repeat (20) @(negedge clk);
        chk("full_no_wr", 32'(tx_cnt - t_tx), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        tx_full = 1'b0;
        repeat (10) @(negedge clk);
        chk("full_one_wr", 32'(tx_cnt - t_tx), 32'd1);
        chk("full_rsp", 32'(last_tx), 32'h4B);

        // Reset in the middle of a write frame
        t_tx = tx_cnt; t_we = we_cnt; t_re = re_cnt;
        push(8'h57); push(8'h02);
        n = 20;
        while (wr_ptr != rd_ptr && n > 0) begin @(negedge clk); n--; end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", all_outs(), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        send_frame(8'h52, 8'h02, 8'h00, 2, 1);
        wait_rsp(t_tx, 1'b0);
        chk("midreset_tx", 32'(tx_cnt - t_tx), 32'd1);
        chk("midreset_rsp", 32'(last_tx), 32'(model_regs[2]));
        chk("midreset_we", 32'(we_cnt - t_we), 32'd0);
        chk("midreset_re", 32'(re_cnt - t_re), 32'd1);

        // Randomized frames against the frame-level model
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(0, 3))
                0: b0 = 8'h57;
                1: b0 = 8'h52;
                2: b0 = 8'h50;
                default: begin
                    b0 = 8'($urandom_range(0, 255));
                    while (b0 == 8'h57 || b0 == 8'h52 || b0 == 8'h50) b0 = 8'($urandom_range(0, 255));
                end
            endcase
            b1 = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
            b2 = 8'($urandom_range(0, 255));
            exp_we = 1'b0; exp_re = 1'b0;
            if (b0 == 8'h57) begin
                n = 3;
                exp_we  = (b1 < 8'd16);
                exp_rsp = exp_we ? 8'h4B : 8'h3F;
            end else if (b0 == 8'h52) begin
                n = 2;
                exp_re  = (b1 < 8'd16);
                exp_rsp = exp_re ? model_regs[b1[3:0]] : 8'h3F;
            end else begin
                n = 1;
                exp_rsp = (b0 == 8'h50) ? 8'h4B : 8'h3F;
            end
            t_tx = tx_cnt; t_we = we_cnt; t_re = re_cnt;
            send_frame(b0, b1, b2, n, 4);
            wait_rsp(t_tx, 1'b1);
            chk($sformatf("rnd%0d_rsp", f), 32'(last_tx), 32'(exp_rsp));
            chk($sformatf("rnd%0d_we", f), 32'(we_cnt - t_we), 32'(exp_we));
            chk($sformatf("rnd%0d_re", f), 32'(re_cnt - t_re), 32'(exp_re));
            if (exp_we) begin
                chk($sformatf("rnd%0d_waddr", f), 32'(we_addr), 32'(b1));
                chk($sformatf("rnd%0d_wdata", f), 32'(we_data), 32'(b2));
                model_regs[b1[3:0]] = b2;
            end
        end

        chk("no_underflow", 32'(underflow), 32'd0);
        chk("no_stray_timeout", 32'(tmo_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
Byte-command engine on the user side of the uart block. It consumes received bytes through the FWFT rx FIFO interface (rx_empty, r_data, rd_uart) and drives responses into the tx FIFO interface (w_data, wr_uart, tx_full). It decodes a 2–3 byte binary command protocol into a simple register bus and returns one response byte per accepted command. An inter-byte timeout aborts partial frames.

Parameters:
AW, 4, register bus address width; legal addresses are 0..2^AW-1
TIMEOUT, 1000000, idle clk cycles allowed between bytes of one frame before abort (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
rx_empty  in  1  rx FIFO empty; r_data is valid whenever 0
r_data  in  8  rx FIFO head byte (first-word-fall-through)
rd_uart  out  1  rx FIFO pop, one-cycle pulse
tx_full  in  1  tx FIFO full
w_data  out  8  response byte, valid while wr_uart=1
wr_uart  out  1  tx FIFO push, one-cycle pulse
reg_addr  out  AW  register bus address
reg_wdata  out  8  register write data
reg_we  out  1  register write strobe, one cycle
reg_re  out  1  register read strobe, one cycle
reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse when a partial frame is aborted

Behaviour:
- Clock/reset as decided: one clock clk; reset_n synchronous, active-low. Reset: state=IDLE, every output 0, timeout counter 0. Reset mid-frame discards the partial frame; no response is sent.
- All outputs are registered.
- Protocol: 0x57 'W', addr, data -> bus write, reply 0x4B 'K'. 0x52 'R', addr -> bus read, reply the read byte. 0x50 'P' -> reply 0x4B. Any other first byte -> reply 0x3F '?'. Address byte with bits [7:AW] nonzero -> no bus access, reply 0x3F; for 'W' the data byte is still consumed first.
- Pop rule: in a receive state with rx_empty=0 and rd_uart=0, set rd_uart=1 for the next cycle and capture r_data at the same edge. While rd_uart=1, rx_empty and r_data are stale and ignored. Minimum is 2 cycles per byte.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND.
- IDLE: on pop, the cmd byte goes to GET_ADDR for W/R, or to SEND with the response preloaded for 'P' or unknown.
- GET_ADDR: on pop, 'W' goes to GET_DATA. 'R' goes to BUS_RD, or to SEND with 0x3F if the address is bad.
- GET_DATA: on pop, goes to BUS_WR, or to SEND with 0x3F if the address is bad.
- BUS_WR: reg_we=1 for one cycle with reg_addr/reg_wdata stable, then SEND with 0x4B.
- BUS_RD: reg_re=1 for one cycle. RD_WAIT: capture reg_rdata, then SEND.
- SEND: when tx_full=0, wr_uart=1 for one cycle with w_data=response, then IDLE. If tx_full=1, wait indefinitely; no timeout applies in SEND.
- Timeout: applies only in GET_ADDR and GET_DATA. The counter clears on every pop and on entering IDLE, and increments each cycle otherwise. When it reaches TIMEOUT-1, go to IDLE, pulse timeout_err, send no response.
- reg_addr and reg_wdata hold their last values outside strobes.
- rx bytes arriving while in SEND or BUS states remain in the FIFO and are not popped.

Decomposition:
- Shared package uart_cmd_pkg: command constants (CMD_WR=0x57, CMD_RD=0x52, CMD_PING=0x50), response constants (RSP_OK=0x4B, RSP_ERR=0x3F), and the state enum.
- One sub-module: uart_cmd_timeout, a loadable cycle counter with clear, enable and a done pulse, sized by $clog2(TIMEOUT).

Test Plan:
- Push 0x57,0x03,0xA5 into the rx model -> reg_we=1 one cycle with reg_addr=3, reg_wdata=0xA5; then wr_uart with w_data=0x4B; busy returns to 0.
- Push 0x52,0x03 with the bus model returning 0xA5 -> reg_re one cycle; wr_uart with w_data=0xA5 two cycles later or more; no reg_we.
- Push 0x41, then 0x52,0x20 with AW=4 -> two responses 0x3F,0x3F; no reg_re or reg_we.
- Push 0x57,0x01, then stall; with TIMEOUT=16 -> timeout_err pulse 16 cycles after the last pop, no wr_uart; a following 0x50 -> 0x4B.
- Hold tx_full=1 and send 0x50 -> stays in SEND, wr_uart=0; release tx_full -> exactly one wr_uart with 0x4B.
- Assert reset_n=0 for one cycle after 0x57,0x02 -> all outputs 0; a next frame 0x52,0x02 is decoded as a fresh command.
